// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: RAM handshake states, arbiter FSM states,
// the machine word and a few widths used by the memory arbiter.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2,
    TRAP   = 2'd3
  } arb_state_t;

  localparam int WD_W     = 8;
  localparam int STARVE_W = 4;

endpackage

// File: rtl/arb_watchdog.sv
// Grant watchdog: counts cycles a grant spends waiting on the RAM.
// Cleared while the arbiter is idle, so every grant starts from zero;
// saturates instead of wrapping; 'expired' flags the last allowed cycle.
module arb_watchdog
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_SAT = {WD_W{1'b1}};

  logic [WD_W-1:0] wd_cnt;

  // Wait counter: clear has priority, then saturating increment.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wd_cnt <= '0;
    end else if (clr) begin
      wd_cnt <= '0;
    end else if (en && (wd_cnt != WD_SAT)) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign expired = (wd_cnt == WD_LIM);

endmodule

// File: rtl/mem_arbiter.sv
// Registered arbiter sharing the unified single-port RAM between fetch
// (instruction read) and the memory stage (data read/write). Data has
// priority; after STARVE_MAX data grants with fetch waiting, one fetch
// grant is forced. A watchdog traps grants stuck waiting on the RAM.
// Optional: define MEM_ARB_STATS_EN to add transaction/stall counters.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic [1:0]  ramstate,
  input  logic [31:0] ramload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic        ihit,
  output logic        dhit,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        err
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0] icount,
  output logic [31:0] dcount,
  output logic [31:0] stall_cycles
`endif
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  arb_state_t          state, next_state;
  logic [STARVE_W-1:0] starve_cnt, starve_nxt;
  logic                dwr, dwr_nxt;
  logic                wd_clr, wd_en, wd_expired;
  ramstate_t           rs;
  logic                access;
  logic                dreq;

  assign rs     = ramstate_t'(ramstate);
  assign access = (rs == ACCESS);
  assign dreq   = dREN | dWEN;
  assign wd_clr = (state == IDLE);
  assign err    = (state == TRAP);

  arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .CLK    (CLK),
    .nRST   (nRST),
    .clr    (wd_clr),
    .en     (wd_en),
    .expired(wd_expired)
  );

  // State, starvation counter and latched write/read type of the data grant.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      starve_cnt <= '0;
      dwr        <= 1'b0;
    end else begin
      state      <= next_state;
      starve_cnt <= starve_nxt;
      dwr        <= dwr_nxt;
    end
  end

  // Arbitration, grant outputs, completion/abort/trap decisions.
  always_comb begin
    next_state = state;
    starve_nxt = starve_cnt;
    dwr_nxt    = dwr;
    wd_en      = 1'b0;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    ihit       = 1'b0;
    dhit       = 1'b0;
    iload      = '0;
    dload      = '0;
    case (state)
      IDLE: begin
        if (iREN && (starve_cnt == STARVE_LIM)) begin
          next_state = IGRANT;
        end else if (dreq) begin
          next_state = DGRANT;
          dwr_nxt    = dWEN;
        end else if (iREN) begin
          next_state = IGRANT;
        end
      end
      IGRANT: begin
        // Completion wins over a same-cycle request drop, so keep the
        // enable up whenever the RAM reports ACCESS.
        ramaddr = iaddr;
        ramREN  = iREN | access;
        if (access) begin
          ihit       = 1'b1;
          iload      = ramload;
          starve_nxt = '0;
          next_state = IDLE;
        end else if (rs == ERROR) begin
          next_state = TRAP;
        end else if (!iREN) begin
          next_state = IDLE;
        end else if (wd_expired) begin
          next_state = TRAP;
        end else begin
          wd_en = 1'b1;
        end
      end
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = (dreq | access) & dwr;
        ramREN   = (dreq | access) & ~dwr;
        if (access) begin
          dhit       = 1'b1;
          dload      = ramload;
          next_state = IDLE;
          if (iREN && (starve_cnt != STARVE_LIM)) begin
            starve_nxt = starve_cnt + 1'b1;
          end
        end else if (rs == ERROR) begin
          next_state = TRAP;
        end else if (!dreq) begin
          next_state = IDLE;
        end else if (wd_expired) begin
          next_state = TRAP;
        end else begin
          wd_en = 1'b1;
        end
      end
      TRAP: begin
        next_state = TRAP;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

`ifdef MEM_ARB_STATS_EN
  // Completed-transaction and fetch-stall counters, wrapping at 2^32.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      icount       <= '0;
      dcount       <= '0;
      stall_cycles <= '0;
    end else begin
      if (ihit) icount <= icount + 32'd1;
      if (dhit) dcount <= dcount + 32'd1;
      if (iREN && (state != IGRANT)) stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: fetch, data priority, starvation
// limit, watchdog trap, abort and RAM error. Stats counters are exercised
// when MEM_ARB_STATS_EN is defined.
module tb_mem_arbiter;

  logic        CLK;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [1:0]  ramstate;
  logic [31:0] ramload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic        ihit;
  logic        dhit;
  logic [31:0] iload;
  logic [31:0] dload;
  logic        err;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] icount;
  logic [31:0] dcount;
  logic [31:0] stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] RS_FREE   = 2'd0;
  localparam logic [1:0] RS_BUSY   = 2'd1;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  mem_arbiter #(
    .STARVE_MAX(4),
    .TIMEOUT   (64)
  ) dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .iREN    (iREN),
    .iaddr   (iaddr),
    .dREN    (dREN),
    .dWEN    (dWEN),
    .daddr   (daddr),
    .dstore  (dstore),
    .ramstate(ramstate),
    .ramload (ramload),
    .ramREN  (ramREN),
    .ramWEN  (ramWEN),
    .ramaddr (ramaddr),
    .ramstore(ramstore),
    .ihit    (ihit),
    .dhit    (dhit),
    .iload   (iload),
    .dload   (dload),
    .err     (err)
`ifdef MEM_ARB_STATS_EN
    ,
    .icount      (icount),
    .dcount      (dcount),
    .stall_cycles(stall_cycles)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0;
    ramstate = RS_FREE; ramload = 32'h0;
    #2;
    checks++;
    if ({ramREN, ramWEN, ihit, dhit, err} !== 5'b0) begin
      errors++; $display("FAIL reset_ctl got %b want 00000", {ramREN, ramWEN, ihit, dhit, err});
    end
    checks++;
    if ({ramaddr, ramstore, iload, dload} !== 128'h0) begin
      errors++; $display("FAIL reset_data got %h %h %h %h want 0", ramaddr, ramstore, iload, dload);
    end
    cyc();
    nRST = 1'b1;
    cyc();
  endtask

  task automatic test_ifetch();
    iREN = 1; iaddr = 32'h40; ramstate = RS_BUSY;
    #2;
    checks++;
    if (ramREN !== 1'b0) begin errors++; $display("FAIL if_idle ramREN got %b want 0", ramREN); end
    cyc();
    #2;
    checks++;
    if ({ramREN, ihit} !== 2'b10 || ramaddr !== 32'h40) begin
      errors++; $display("FAIL if_busy1 ren/hit got %b addr %h want 10 addr 40", {ramREN, ihit}, ramaddr);
    end
    cyc();
    #2;
    checks++;
    if ({ramREN, ihit} !== 2'b10) begin errors++; $display("FAIL if_busy2 got %b want 10", {ramREN, ihit}); end
    cyc();
    ramstate = RS_ACCESS; ramload = 32'h8C010004;
    #2;
    checks++;
    if (ihit !== 1'b1 || iload !== 32'h8C010004) begin
      errors++; $display("FAIL if_hit got ihit %b iload %h want 1 8c010004", ihit, iload);
    end
    cyc();
    iREN = 0; ramstate = RS_FREE;
    #2;
    checks++;
    if ({ramREN, ihit} !== 2'b00 || iload !== 32'h0) begin
      errors++; $display("FAIL if_after got %b iload %h want 00 0", {ramREN, ihit}, iload);
    end
    cyc();
  endtask

  task automatic test_priority();
    iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF;
    ramstate = RS_FREE;
    cyc();
    ramstate = RS_ACCESS; ramload = 32'h0000_5555;
    #2;
    checks++;
    if ({ramWEN, ramREN, dhit, ihit} !== 4'b1010) begin
      errors++; $display("FAIL pri_dgrant got %b want 1010", {ramWEN, ramREN, dhit, ihit});
    end
    checks++;
    if (ramaddr !== 32'h100 || ramstore !== 32'hDEADBEEF || dload !== 32'h0000_5555) begin
      errors++; $display("FAIL pri_dbus got %h %h %h want 100 deadbeef 5555", ramaddr, ramstore, dload);
    end
    cyc();
    dWEN = 0; ramstate = RS_FREE;
    #2;
    checks++;
    if ({ramREN, ramWEN, ihit, dhit} !== 4'b0000) begin
      errors++; $display("FAIL pri_bubble got %b want 0000", {ramREN, ramWEN, ihit, dhit});
    end
    cyc();
    ramstate = RS_ACCESS; ramload = 32'h1234;
    #2;
    checks++;
    if ({ramREN, ihit} !== 2'b11 || ramaddr !== 32'h44 || iload !== 32'h1234) begin
      errors++; $display("FAIL pri_igrant got %b addr %h iload %h want 11 44 1234", {ramREN, ihit}, ramaddr, iload);
    end
    cyc();
    iREN = 0; ramstate = RS_FREE;
    cyc();
  endtask

  task automatic test_starvation();
    logic exp_i, exp_d;
    iREN = 1; iaddr = 32'h200; dREN = 1; daddr = 32'h300;
    ramstate = RS_ACCESS; ramload = 32'hA5A5;
    for (int t = 0; t < 12; t++) begin
      #2;
      exp_i = 1'b0; exp_d = 1'b0;
      if (t % 2 == 1) begin
        if (t / 2 == 4) exp_i = 1'b1;
        else            exp_d = 1'b1;
      end
      checks++;
      if (ihit !== exp_i || dhit !== exp_d) begin
        errors++; $display("FAIL starve_t%0d got i%b d%b want i%b d%b", t, ihit, dhit, exp_i, exp_d);
      end
      cyc();
    end
    iREN = 0; dREN = 0; ramstate = RS_FREE;
    cyc();
  endtask

  task automatic test_watchdog();
    int bad;
    nRST = 0; #1; nRST = 1;
    dREN = 1; daddr = 32'h80; ramstate = RS_BUSY;
    cyc();
    bad = 0;
    for (int k = 0; k < 64; k++) begin
      #2;
      checks++;
      if (ramREN !== 1'b1 || dhit !== 1'b0 || err !== 1'b0) begin
        errors++; bad++;
        if (bad < 4) $display("FAIL wd_wait_%0d got ren%b hit%b err%b want 1 0 0", k, ramREN, dhit, err);
      end
      cyc();
    end
    #2;
    checks++;
    if (err !== 1'b1 || ramREN !== 1'b0) begin
      errors++; $display("FAIL wd_trap got err%b ren%b want 1 0", err, ramREN);
    end
    ramstate = RS_ACCESS;
    cyc(); cyc();
    #2;
    checks++;
    if (err !== 1'b1 || dhit !== 1'b0 || ramREN !== 1'b0) begin
      errors++; $display("FAIL wd_sticky got err%b hit%b ren%b want 1 0 0", err, dhit, ramREN);
    end
    nRST = 0;
    #1;
    checks++;
    if (err !== 1'b0 || ramREN !== 1'b0) begin
      errors++; $display("FAIL wd_reset got err%b ren%b want 0 0", err, ramREN);
    end
    dREN = 0; ramstate = RS_FREE;
    cyc();
    nRST = 1;
    cyc();
  endtask

  task automatic test_abort_error();
    dREN = 1; daddr = 32'h90; ramstate = RS_BUSY;
    cyc();
    #2;
    checks++;
    if (ramREN !== 1'b1) begin errors++; $display("FAIL ab_busy1 ramREN got %b want 1", ramREN); end
    cyc();
    dREN = 0;
    #2;
    checks++;
    if ({ramREN, ramWEN, dhit} !== 3'b000) begin
      errors++; $display("FAIL ab_drop got %b want 000", {ramREN, ramWEN, dhit});
    end
    cyc();
    iREN = 1; iaddr = 32'hC0; ramstate = RS_ERROR;
    #2;
    checks++;
    if (ramREN !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL ab_idle got ren%b err%b want 0 0", ramREN, err);
    end
    cyc();
    #2;
    checks++;
    if (ramREN !== 1'b1 || ramaddr !== 32'hC0 || ihit !== 1'b0) begin
      errors++; $display("FAIL ab_igrant got ren%b addr %h hit%b want 1 c0 0", ramREN, ramaddr, ihit);
    end
    cyc();
    #2;
    checks++;
    if (err !== 1'b1 || ramREN !== 1'b0) begin
      errors++; $display("FAIL ram_error got err%b ren%b want 1 0", err, ramREN);
    end
    iREN = 0; ramstate = RS_FREE;
    nRST = 0;
    cyc();
    nRST = 1;
    cyc();
  endtask

`ifdef MEM_ARB_STATS_EN
  task automatic test_stats();
    nRST = 0; #1; nRST = 1;
    ramstate = RS_ACCESS; ramload = 32'h77;
    for (int n = 0; n < 2; n++) begin
      iREN = 1; iaddr = 32'h10;
      cyc(); cyc();
      iREN = 0;
      cyc();
    end
    iREN = 1; dREN = 1; daddr = 32'h20;
    cyc(); cyc();
    dREN = 0;
    cyc(); cyc();
    iREN = 0;
    cyc();
    dREN = 1;
    cyc(); cyc();
    dREN = 0;
    cyc();
    #2;
    checks++;
    if (icount !== 32'd3 || dcount !== 32'd2) begin
      errors++; $display("FAIL stats_counts got i%0d d%0d want i3 d2", icount, dcount);
    end
    checks++;
    if (stall_cycles !== 32'd5) begin
      errors++; $display("FAIL stats_stall got %0d want 5", stall_cycles);
    end
    ramstate = RS_FREE;
    cyc();
  endtask
`endif

  initial begin
    test_reset();
    test_ifetch();
    test_priority();
    test_starvation();
    test_watchdog();
    test_abort_error();
`ifdef MEM_ARB_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Registered arbiter that shares the single-port unified RAM between the fetch stage (instruction read) and the memory stage (data read/write).
- Generates the ihit/dhit strobes that advance the pipeline latches, including the write-back latch.
- Data accesses have priority, bounded by an anti-starvation limit for fetch; a watchdog traps stuck RAM transactions.

Parameters:
- STARVE_MAX, 4, consecutive data grants issued while iREN is pending before one instruction grant is forced (1..15).
- TIMEOUT, 64, cycles a grant may wait for ramstate==ACCESS before trapping (2..255).

Ports:
- CLK  in  1  clock
- nRST  in  1  reset
- iREN  in  1  instruction read request, held until ihit
- iaddr  in  32  instruction address
- dREN  in  1  data read request, held until dhit
- dWEN  in  1  data write request, held until dhit
- daddr  in  32  data address
- dstore  in  32  data write value
- ramstate  in  2  ramstate_t from RAM
- ramload  in  32  RAM read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ihit  out  1  instruction access done (1-cycle pulse)
- dhit  out  1  data access done (1-cycle pulse)
- iload  out  32  instruction word (valid when ihit)
- dload  out  32  data word (valid when dhit)
- err  out  1  sticky trap flag

Behaviour:
- Reset: nRST asynchronous, active-low; clock CLK.
  - Reset state: IDLE, starve_cnt=0, wd_cnt=0.
  - Reset outputs: ramREN=ramWEN=0, ramaddr=ramstore=0, ihit=dhit=0, iload=dload=0, err=0.
  - Reset mid-grant aborts the access immediately; no hit is issued.
- FSM states: IDLE, IGRANT, DGRANT, TRAP.
- IDLE arbitration, evaluated each cycle:
  - If iREN && starve_cnt==STARVE_MAX → IGRANT.
  - Else if dREN|dWEN → DGRANT.
  - Else if iREN → IGRANT.
  - Else stay in IDLE.
- Grant outputs:
  - IGRANT: ramREN=1, ramaddr=iaddr.
  - DGRANT: ramaddr=daddr, ramstore=dstore.
    - If dWEN: ramWEN=1, ramREN=0; dWEN wins when both dREN and dWEN are set.
    - Else: ramREN=1.
  - All RAM outputs are 0 in IDLE and TRAP.
- Completion:
  - In a grant with ramstate==ACCESS: ihit (or dhit) =1 combinationally that cycle; iload/dload=ramload; next state IDLE.
  - A one-cycle bubble follows every transaction, so minimum access latency is request→hit = 2 cycles.
  - iload/dload are 0 whenever the corresponding hit is 0.
- ramstate FREE/BUSY: stay in the grant; wd_cnt increments (saturating).
- Abort: owner's request deasserted before ACCESS → RAM enables drop the same cycle, next state IDLE, no hit, starve_cnt unchanged.
- Watchdog:
  - wd_cnt clears on entering any grant.
  - wd_cnt reaching TIMEOUT-1 while still not ACCESS → TRAP.
- ramstate==ERROR in any grant → TRAP.
- TRAP: err=1, no grants, no hits; exited only by reset.
- starve_cnt:
  - +1 (saturating at STARVE_MAX) on DGRANT completion if iREN was high that cycle.
  - Cleared on IGRANT completion.
  - Unchanged on DGRANT completion with iREN low.
- Simultaneous ACCESS and request change: completion takes precedence over abort.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- With it defined:
  - Adds outputs icount[31:0], dcount[31:0] and stall_cycles[31:0].
  - icount/dcount: completed instruction/data transactions.
  - stall_cycles: cycles with iREN asserted and state!=IGRANT.
  - All three wrap at 2^32 and reset to 0.
- Without it: no such ports or registers.

Decomposition:
- Shared package cpu_types_pkg:
  - ramstate_t (FREE=0, BUSY=1, ACCESS=2, ERROR=3).
  - arb_state_t (IDLE, IGRANT, DGRANT, TRAP).
  - word_t.
- Sub-module arb_watchdog: saturating counter with clear, enable and TIMEOUT compare, exposing an expired output.

Test Plan:
- iREN=1, iaddr=0x40, RAM returns ACCESS after 2 BUSY cycles with ramload=0x8C010004 → ramREN=1, ramaddr=0x40; ihit pulses 1 cycle with iload=0x8C010004; FSM returns to IDLE.
- iREN=1 and dWEN=1 asserted together, daddr=0x100, dstore=0xDEADBEEF → DGRANT first, ramWEN=1; dhit; bubble; then IGRANT and ihit.
- iREN held, dREN re-asserted after every dhit, STARVE_MAX=4 → exactly 4 dhits, then 1 ihit, then data grants resume.
- dREN=1, ramstate stuck BUSY, TIMEOUT=64 → TRAP after 64 cycles; err=1 sticky; no dhit; nRST clears err.
- dREN dropped on the 2nd BUSY cycle → ramREN=0 the same cycle, no dhit, IDLE the next cycle; ramstate=ERROR in a later grant → err=1.
- With MEM_ARB_STATS_EN defined: 3 instruction and 2 data transactions → icount=3, dcount=2; stall_cycles matches the bench's count of iREN-waiting cycles.
